// File: rtl/io_arb_pkg.sv
// Shared types and helpers for the IO writeback arbiter.
// IO_WB_ARB_ROUNDROBIN_EN selects round-robin over fixed priority.
package io_arb_pkg;

   localparam int unsigned IOWB_MAXPORTS = 8;
   localparam int unsigned IOWB_REGADDRBITS = 4;
   localparam int unsigned IOWB_DATABITS = 16;

   typedef struct packed {
      logic [IOWB_REGADDRBITS-1:0] DestReg;
      logic [IOWB_DATABITS-1:0]    Data;
   } io_wb_entry_t;

   function automatic int unsigned wrapAdd(int unsigned a, int unsigned b, int unsigned m);
      return (a + b) % m;
   endfunction

endpackage

// File: rtl/io_wb_arb_select.sv
// Combinational winner selection: one-hot grant plus its index.
// IO_WB_ARB_ROUNDROBIN_EN scans from Ptr; otherwise lowest index wins.
module io_wb_arb_select
   import io_arb_pkg::*;
#(
   parameter int unsigned PORTS = 4,
   localparam int unsigned IDXW = $clog2(PORTS)
) (
   input  logic [PORTS-1:0] Req_In,
`ifdef IO_WB_ARB_ROUNDROBIN_EN
   input  logic [IDXW-1:0]  Ptr,
`endif
   output logic [PORTS-1:0] Grant,
   output logic [IDXW-1:0]  WinIdx,
   output logic             AnyReq
);

   assign AnyReq = |Req_In;

`ifdef IO_WB_ARB_ROUNDROBIN_EN
   always_comb begin
      int unsigned idx;
      logic found;
      idx    = 0;
      found  = 1'b0;
      WinIdx = '0;
      for (int unsigned k = 0; k < PORTS; k++) begin
         idx = wrapAdd(int'(Ptr), k, PORTS);
         if (!found && Req_In[idx]) begin
            found  = 1'b1;
            WinIdx = IDXW'(idx);
         end
      end
   end
`else
   always_comb begin
      WinIdx = '0;
      // Descending scan so the lowest set index is the last writer.
      for (int k = PORTS - 1; k >= 0; k--) begin
         if (Req_In[k]) WinIdx = IDXW'(k);
      end
   end
`endif

   always_comb begin
      Grant = '0;
      if (AnyReq) Grant[WinIdx] = 1'b1;
   end

endmodule

// File: rtl/io_writeback_arbiter.sv
// Arbitrates PORTS IO responders onto the single CPU writeback channel.
// IO_WB_ARB_ROUNDROBIN_EN enables the rotating priority pointer.
module io_writeback_arbiter
   import io_arb_pkg::*;
#(
   parameter int unsigned PORTS        = 4,
   parameter int unsigned DATABITWIDTH = 16,
   parameter int unsigned REGADDRBITS  = 4,
   localparam int unsigned IDXW        = $clog2(PORTS)
) (
   input  logic                            clk,
   input  logic                            sync_rst,
   input  logic                            clk_en,
   input  logic [PORTS-1:0]                Req_In,
   output logic [PORTS-1:0]                Ack_Out,
   input  logic [PORTS*REGADDRBITS-1:0]    DestReg_In,
   input  logic [PORTS*DATABITWIDTH-1:0]   Data_In,
   output logic                            WB_REQ,
   input  logic                            WB_ACK,
   output logic [REGADDRBITS-1:0]          WB_DestReg,
   output logic [DATABITWIDTH-1:0]         WB_Data,
   output logic [IDXW-1:0]                 GrantIdx
);

   logic                    fullQ;
   logic [REGADDRBITS-1:0]  destRegQ;
   logic [DATABITWIDTH-1:0] dataQ;
   logic [IDXW-1:0]         grantIdxQ;
   logic [PORTS-1:0]        grant;
   logic [IDXW-1:0]         winIdx;
   logic                    anyReq;
   logic                    load;

`ifdef IO_WB_ARB_ROUNDROBIN_EN
   logic [IDXW-1:0] ptrQ;
`endif

   io_wb_arb_select #(
      .PORTS(PORTS)
   ) uSelect (
      .Req_In (Req_In),
`ifdef IO_WB_ARB_ROUNDROBIN_EN
      .Ptr    (ptrQ),
`endif
      .Grant  (grant),
      .WinIdx (winIdx),
      .AnyReq (anyReq)
   );

   // Reset gates the load so no requester sees an accept it would then lose.
   assign load    = clk_en & ~sync_rst & (~fullQ | WB_ACK) & anyReq;
   assign Ack_Out = load ? grant : '0;

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         fullQ     <= 1'b0;
         destRegQ  <= '0;
         dataQ     <= '0;
         grantIdxQ <= '0;
`ifdef IO_WB_ARB_ROUNDROBIN_EN
         ptrQ      <= '0;
`endif
      end else if (load) begin
         fullQ     <= 1'b1;
         destRegQ  <= DestReg_In[int'(winIdx)*REGADDRBITS +: REGADDRBITS];
         dataQ     <= Data_In[int'(winIdx)*DATABITWIDTH +: DATABITWIDTH];
         grantIdxQ <= winIdx;
`ifdef IO_WB_ARB_ROUNDROBIN_EN
         ptrQ      <= IDXW'(wrapAdd(int'(winIdx), 1, PORTS));
`endif
      end else if (clk_en && fullQ && WB_ACK) begin
         fullQ <= 1'b0;
      end
   end

   assign WB_REQ     = fullQ;
   assign WB_DestReg = destRegQ;
   assign WB_Data    = dataQ;
   assign GrantIdx   = grantIdxQ;

endmodule
